// File: rtl/spi_pkg.sv
// Shared SPI definitions: command codes, fill byte and the MISO transmitter state type.
package spi_pkg;

   localparam logic [7:0] COMMAND_NOP          = 8'h00;
   localparam logic [7:0] COMMAND_READ_STATUS  = 8'h01;
   localparam logic [7:0] COMMAND_READ_FRAME   = 8'h02;
   localparam logic [7:0] COMMAND_WRITE_SPRITE = 8'h10;

   // Sent whenever the response FIFO is empty at a byte boundary.
   localparam logic [7:0] FILL_BYTE = 8'hFF;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } spi_tx_state_t;

endpackage

// File: rtl/negedge_detect.sv
// One-cycle pulse when an already-synchronised level goes from 1 to 0.
module negedge_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic fall
);

   logic prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) prev <= RESET_VAL;
      else        prev <= sig;
   end

   assign fall = ~sig & prev;

endmodule

// File: rtl/posedge_detect.sv
// One-cycle pulse when an already-synchronised level goes from 0 to 1.
module posedge_detect #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic prev;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) prev <= RESET_VAL;
      else        prev <= sig;
   end

   assign rise = sig & ~prev;

endmodule

// File: rtl/spi_tx_fifo.sv
// Synchronous byte FIFO for queued SPI responses; DEPTH must be a power of 2.
module spi_tx_fifo #(
   parameter  int DEPTH = 16,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          push,
   input  logic [7:0]    push_data,
   input  logic          pop,
   output logic [7:0]    head,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   level
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr];
   assign level   = count;

   always_ff @(posedge clock) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of 2.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/spi_miso_writer.sv
// SPI mode-0 slave transmitter: serialises queued response bytes MSB first on miso.
// Define SPI_MISO_TRISTATE_EN to release miso (1'bz) while idle.
module spi_miso_writer
   import spi_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          cs,
   input  logic                          sck,
   output logic                          miso,
   input  logic [7:0]                    tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic                          byte_sent,
   output logic                          underrun,
   input  logic                          underrun_clear,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output spi_tx_state_t                 state_dbg
);

   logic [SYNC_STAGES-1:0] sck_sync;
   logic [SYNC_STAGES-1:0] cs_sync;
   logic sck_rise, sck_fall, cs_rise, cs_fall;

   spi_tx_state_t state, state_n;
   logic [7:0] shift_reg, shift_n;
   logic [3:0] rise_cnt, rise_n;
   logic       miso_q, miso_n;
   logic       byte_sent_n;
   logic       underrun_n;
   logic       set_underrun;
   logic       load_byte;
   logic       fifo_pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic [7:0] fifo_head;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sck_sync <= '0;
         cs_sync  <= '1;
      end else begin
         sck_sync[0] <= sck;
         cs_sync[0]  <= cs;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sck_sync[i] <= sck_sync[i-1];
            cs_sync[i]  <= cs_sync[i-1];
         end
      end
   end

   posedge_detect #(.RESET_VAL(1'b0)) u_sck_rise (
      .clock(clock), .reset(reset), .sig(sck_sync[SYNC_STAGES-1]), .rise(sck_rise));
   negedge_detect #(.RESET_VAL(1'b0)) u_sck_fall (
      .clock(clock), .reset(reset), .sig(sck_sync[SYNC_STAGES-1]), .fall(sck_fall));
   posedge_detect #(.RESET_VAL(1'b1)) u_cs_rise (
      .clock(clock), .reset(reset), .sig(cs_sync[SYNC_STAGES-1]), .rise(cs_rise));
   negedge_detect #(.RESET_VAL(1'b1)) u_cs_fall (
      .clock(clock), .reset(reset), .sig(cs_sync[SYNC_STAGES-1]), .fall(cs_fall));

   spi_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         shift_reg <= '0;
         rise_cnt  <= '0;
         miso_q    <= 1'b1;
         byte_sent <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_n;
         shift_reg <= shift_n;
         rise_cnt  <= rise_n;
         miso_q    <= miso_n;
         byte_sent <= byte_sent_n;
         underrun  <= underrun_n;
      end
   end

   always_comb begin
      state_n      = state;
      shift_n      = shift_reg;
      rise_n       = rise_cnt;
      miso_n       = miso_q;
      byte_sent_n  = 1'b0;
      set_underrun = 1'b0;
      load_byte    = 1'b0;
      fifo_pop     = 1'b0;

      case (state)
         IDLE: begin
            miso_n = 1'b1;
            if (cs_fall) begin
               load_byte = 1'b1;
               rise_n    = 4'd0;
               state_n   = SHIFT;
            end
         end
         SHIFT: begin
            // Deselect wins over any sck edge; a partial byte is simply dropped.
            if (cs_rise) begin
               state_n = IDLE;
               miso_n  = 1'b1;
            end else if (sck_rise) begin
               if (rise_cnt != 4'd8) rise_n = rise_cnt + 4'd1;
            end else if (sck_fall) begin
               if (rise_cnt == 4'd8) begin
                  byte_sent_n = 1'b1;
                  rise_n      = 4'd0;
                  load_byte   = 1'b1;
               end else begin
                  shift_n = {shift_reg[6:0], 1'b0};
                  miso_n  = shift_reg[6];
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // Only the registered empty flag is consulted, so a same-cycle push stays queued.
      if (load_byte) begin
         if (fifo_empty) begin
            shift_n      = FILL_BYTE;
            set_underrun = 1'b1;
         end else begin
            shift_n  = fifo_head;
            fifo_pop = 1'b1;
         end
         miso_n = shift_n[7];
      end

      underrun_n = set_underrun | (underrun & ~underrun_clear);
   end

   assign tx_ready  = ~fifo_full;
   assign state_dbg = state;

`ifdef SPI_MISO_TRISTATE_EN
   assign miso = (state == IDLE) ? 1'bz : miso_q;
`else
   assign miso = miso_q;
`endif

endmodule

// File: tb/tb_spi_miso_writer.sv
// Directed bench for spi_miso_writer: host-side SPI master model with a byte scoreboard.
module tb_spi_miso_writer;
   import spi_pkg::*;

   localparam int FIFO_DEPTH  = 16;
   localparam int SYNC_STAGES = 2;
`ifdef SPI_MISO_TRISTATE_EN
   localparam logic IDLE_MISO = 1'bz;
`else
   localparam logic IDLE_MISO = 1'b1;
`endif

   logic        clock;
   logic        reset;
   logic        cs;
   logic        sck;
   logic        miso;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        byte_sent;
   logic        underrun;
   logic        underrun_clear;
   logic [4:0]  fifo_level;
   spi_tx_state_t state_dbg;

   int vectors = 0;
   int errors  = 0;
   int bs_cnt  = 0;
   int bs_base;
   logic [7:0] rx;
   logic [7:0] exp_q[$];

   spi_miso_writer #(.FIFO_DEPTH(FIFO_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clock          (clock),
      .reset          (reset),
      .cs             (cs),
      .sck            (sck),
      .miso           (miso),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .byte_sent      (byte_sent),
      .underrun       (underrun),
      .underrun_clear (underrun_clear),
      .fifo_level     (fifo_level),
      .state_dbg      (state_dbg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (byte_sent === 1'b1) bs_cnt <= bs_cnt + 1;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
         $error("%s miscompare", tag);
      end
   endtask

   task automatic push(input logic [7:0] b);
      tx_data  = b;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
   endtask

   task automatic clear_underrun();
      underrun_clear = 1'b1;
      tick(1);
      underrun_clear = 1'b0;
      tick(1);
   endtask

   // sck at clock/10; host samples miso as it raises sck.
   task automatic spi_xfer(input int nbits, input bit last_fall, output logic [7:0] data);
      data = 8'h00;
      for (int i = 0; i < nbits; i++) begin
         sck  = 1'b1;
         data = {data[6:0], miso};
         tick(5);
         if (i < nbits - 1 || last_fall) begin
            sck = 1'b0;
            tick(5);
         end
      end
   endtask

   initial begin
      reset = 1'b0; cs = 1'b1; sck = 1'b0;
      tx_data = 8'h00; tx_valid = 1'b0; underrun_clear = 1'b0;
      tick(3);
      check("rst_miso",      32'(miso),       32'(IDLE_MISO));
      check("rst_byte_sent", 32'(byte_sent),  32'd0);
      check("rst_underrun",  32'(underrun),   32'd0);
      check("rst_level",     32'(fifo_level), 32'd0);
      check("rst_tx_ready",  32'(tx_ready),   32'd1);
      check("rst_state",     32'(state_dbg),  32'(IDLE));
      reset = 1'b1;
      tick(3);

      // Two queued bytes, two full bytes on the wire.
      push(8'hA5); exp_q.push_back(8'hA5);
      push(8'h3C); exp_q.push_back(8'h3C);
      tick(1);
      check("t1_level2", 32'(fifo_level), 32'd2);
      bs_base = bs_cnt;
      cs = 1'b0; tick(10);
      check("t1_state_shift", 32'(state_dbg), 32'(SHIFT));
      spi_xfer(8, 1'b1, rx);
      check("t1_byte0", 32'(rx), 32'(exp_q.pop_front()));
      check("t1_underrun_mid", 32'(underrun), 32'd0);
      check("t1_level_mid", 32'(fifo_level), 32'd0);
      spi_xfer(8, 1'b1, rx);
      check("t1_byte1", 32'(rx), 32'(exp_q.pop_front()));
      check("t1_byte_sent_cnt", 32'(bs_cnt - bs_base), 32'd2);
      // The trailing falling edge preloads a third byte from an empty FIFO.
      check("t1_underrun_after", 32'(underrun), 32'd1);
      check("t1_level_end", 32'(fifo_level), 32'd0);
      cs = 1'b1; tick(10);
      check("t1_miso_idle", 32'(miso), 32'(IDLE_MISO));

      // Empty FIFO: fill byte, underrun set/clear behaviour.
      clear_underrun();
      check("t2_underrun_cleared", 32'(underrun), 32'd0);
      cs = 1'b0; tick(10);
      check("t2_underrun_set", 32'(underrun), 32'd1);
      spi_xfer(8, 1'b0, rx);
      check("t2_fill_byte", 32'(rx), 32'(FILL_BYTE));
      cs = 1'b1; tick(2); sck = 1'b0; tick(8);
      clear_underrun();
      check("t2_underrun_clear", 32'(underrun), 32'd0);
      cs = 1'b0;
      tick(2);
      underrun_clear = 1'b1;
      tick(1);
      underrun_clear = 1'b0;
      tick(1);
      check("t2_set_beats_clear", 32'(underrun), 32'd1);
      cs = 1'b1; tick(10);
      clear_underrun();

      // Fill the FIFO, overflow push is dropped.
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         push(8'h10 + 8'(i));
         exp_q.push_back(8'h10 + 8'(i));
      end
      tick(1);
      check("t3_tx_ready_full", 32'(tx_ready), 32'd0);
      check("t3_level_full", 32'(fifo_level), 32'd16);
      push(8'h77);
      tick(1);
      check("t3_level_after_ovf", 32'(fifo_level), 32'd16);
      cs = 1'b0; tick(10);
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         spi_xfer(8, 1'b1, rx);
         check($sformatf("t3_byte%0d", i), 32'(rx), 32'(exp_q.pop_front()));
      end
      check("t3_level_empty", 32'(fifo_level), 32'd0);
      check("t3_tx_ready_empty", 32'(tx_ready), 32'd1);
      check("t3_no_77_left", 32'(underrun), 32'd1);
      cs = 1'b1; tick(10);
      clear_underrun();

      // Aborted byte is dropped; next transaction sends the following byte.
      push(8'h81);
      push(8'h42);
      bs_base = bs_cnt;
      cs = 1'b0; tick(10);
      spi_xfer(3, 1'b1, rx);
      check("t4_partial_bits", 32'(rx), 32'h04);
      cs = 1'b1; tick(10);
      check("t4_no_byte_sent", 32'(bs_cnt - bs_base), 32'd0);
      check("t4_level1", 32'(fifo_level), 32'd1);
      check("t4_miso_idle", 32'(miso), 32'(IDLE_MISO));
      cs = 1'b0; tick(10);
      spi_xfer(8, 1'b0, rx);
      check("t4_next_byte", 32'(rx), 32'h42);
      // cs rises after the 8th rising edge with no falling edge: no pulse.
      cs = 1'b1; tick(2); sck = 1'b0; tick(8);
      check("t4_no_pulse_8rise", 32'(bs_cnt - bs_base), 32'd0);
      check("t4_underrun_quiet", 32'(underrun), 32'd0);
      check("t4_state_idle", 32'(state_dbg), 32'(IDLE));

      // Asynchronous reset in the middle of a byte.
      push(8'hA5);
      push(8'h5A);
      cs = 1'b0; tick(10);
      spi_xfer(1, 1'b1, rx);
      check("t5_miso_pre", 32'(miso), 32'd0);
      check("t5_level_pre", 32'(fifo_level), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("t5_miso_rst", 32'(miso), 32'(IDLE_MISO));
      check("t5_level_rst", 32'(fifo_level), 32'd0);
      check("t5_byte_sent_rst", 32'(byte_sent), 32'd0);
      check("t5_tx_ready_rst", 32'(tx_ready), 32'd1);
      cs = 1'b1; sck = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(3);

`ifdef SPI_MISO_TRISTATE_EN
      check("t6_miso_z", 32'(miso), 32'(1'bz));
      push(8'hC3);
      cs = 1'b0;
      tick(SYNC_STAGES + 2);
      check("t6_miso_bit7", 32'(miso), 32'd1);
      cs = 1'b1; tick(10);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
